parking_gate_ctrl: RTL and testbench

//  Sensor-sequencing controller for the lot occupancy counter. Decodes two gate photo sensors
//  (outer a, inner b) into one-cycle enter/exit pulses on io[1:0], which drive the counter's io input.

---
 rtl/parking_gate_ctrl.sv | 160 ++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Gate sensor sequencer: synchronizes and debounces the outer/inner photo
// sensors, tracks legal entry/exit passages and emits one-cycle enter/exit
// pulses for the occupancy counter, plus full/empty flags from its count.
module parking_gate_ctrl #(
  parameter int CAPACITY = 25,
  parameter int DEBOUNCE = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic [5:0] count,
  output logic [1:0] io,
  output logic       full,
  output logic       empty,
  output logic       reject,
  output logic       fault
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE);
  localparam logic [DW-1:0] DB_ONE = DW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [5:0]    CAP    = 6'(CAPACITY);

  typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, ERR} state_t;

  logic [1:0]    sync_p0, sync_p1;
  logic [1:0]    cand;
  logic [DW-1:0] dcnt;
  logic [1:0]    pf, pf_d;
  logic          chg;
  state_t        st, st_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [1:0]    io_n;
  logic          rej_n, flt_n;

  // Two-flop synchronizer followed by a hold-count filter producing pf.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
      cand    <= 2'b00;
      dcnt    <= '0;
      pf      <= 2'b00;
      pf_d    <= 2'b00;
    end else begin
      sync_p0 <= {a, b};
      sync_p1 <= sync_p0;
      pf_d    <= pf;
      if (sync_p1 != cand) begin
        cand <= sync_p1;
        dcnt <= DB_ONE;
        if (DEBOUNCE == 1) pf <= sync_p1;
      end else begin
        if (dcnt != DB_MAX) dcnt <= dcnt + DB_ONE;
        if (dcnt >= DB_MAX - DB_ONE) pf <= cand;
      end
    end
  end

  assign chg = (pf != pf_d);

  // Occupancy flags track the counter with one cycle of latency.
  always_ff @(posedge clk) begin
    full  <= (count >= CAP);
    empty <= (count == 6'd0);
  end

  // State, timer and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= IDLE;
      tmr    <= '0;
      io     <= 2'b00;
      reject <= 1'b0;
      fault  <= 1'b0;
    end else begin
      st     <= st_n;
      tmr    <= tmr_n;
      io     <= io_n;
      reject <= rej_n;
      fault  <= flt_n;
    end
  end

  // Passage sequencing: moves only on accepted pattern changes or timeout.
  always_comb begin
    st_n  = st;
    io_n  = 2'b00;
    rej_n = 1'b0;
    case (st)
      IDLE: if (chg) begin
        case (pf)
          2'b10:   st_n = E1;
          2'b01:   st_n = X1;
          2'b11:   st_n = ERR;
          default: st_n = IDLE;
        endcase
      end
      E1: if (chg) begin
        case (pf)
          2'b11:   st_n = E2;
          2'b00:   st_n = IDLE;
          default: st_n = ERR;
        endcase
      end else if (tmr == T_LAST) st_n = ERR;
      E2: if (chg) begin
        case (pf)
          2'b01:   st_n = E3;
          2'b10:   st_n = E1;
          default: st_n = ERR;
        endcase
      end else if (tmr == T_LAST) st_n = ERR;
      E3: if (chg) begin
        case (pf)
          2'b00: begin
            st_n  = IDLE;
            io_n  = full ? 2'b00 : 2'b10;
            rej_n = full;
          end
          2'b11:   st_n = E2;
          default: st_n = ERR;
        endcase
      end else if (tmr == T_LAST) st_n = ERR;
      X1: if (chg) begin
        case (pf)
          2'b11:   st_n = X2;
          2'b00:   st_n = IDLE;
          default: st_n = ERR;
        endcase
      end else if (tmr == T_LAST) st_n = ERR;
      X2: if (chg) begin
        case (pf)
          2'b10:   st_n = X3;
          2'b01:   st_n = X1;
          default: st_n = ERR;
        endcase
      end else if (tmr == T_LAST) st_n = ERR;
      X3: if (chg) begin
        case (pf)
          2'b00: begin
            st_n = IDLE;
            io_n = empty ? 2'b00 : 2'b01;
          end
          2'b11:   st_n = X2;
          default: st_n = ERR;
        endcase
      end else if (tmr == T_LAST) st_n = ERR;
      ERR: if (pf == 2'b00) st_n = IDLE;
      default: st_n = IDLE;
    endcase
    flt_n = (st_n == ERR) && (st != ERR);
    tmr_n = (chg || st == IDLE || st == ERR) ? '0 : tmr + T_ONE;
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl driving a live occupancy counter.
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [5:0] count = 6'd0;
  logic [1:0] io;
  logic       full, empty, reject, fault;

  logic       ld = 1'b0;
  logic [5:0] ld_val = 6'd0;

  int nchk = 0;
  int nerr = 0;
  int n_enter = 0, n_exit = 0, n_rej = 0, n_fault = 0, n_both = 0;
  int b_enter, b_exit, b_rej, b_fault;

  parking_gate_ctrl #(.CAPACITY(25), .DEBOUNCE(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .count(count),
    .io(io), .full(full), .empty(empty), .reject(reject), .fault(fault)
  );

  always #5 clk = ~clk;

  // Occupancy counter fed by the io pulses, with a bench preload.
  always @(posedge clk) begin
    if (reset) count <= 6'd0;
    else if (ld) count <= ld_val;
    else if (io == 2'b10 && count != 6'd63) count <= count + 6'd1;
    else if (io == 2'b01 && count != 6'd0) count <= count - 6'd1;
  end

  // Pulse tallies taken mid-cycle.
  always @(negedge clk) begin
    if (io == 2'b10) n_enter++;
    if (io == 2'b01) n_exit++;
    if (io == 2'b11) n_both++;
    if (reject) n_rej++;
    if (fault) n_fault++;
  end

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    {a, b} = ab;
    step(n);
  endtask

  task automatic load(input logic [5:0] v);
    ld_val = v;
    ld = 1'b1;
    step(1);
    ld = 1'b0;
  endtask

  task automatic snap();
    b_enter = n_enter;
    b_exit  = n_exit;
    b_rej   = n_rej;
    b_fault = n_fault;
  endtask

  task automatic do_entry();
    hold(2'b10, 8); hold(2'b11, 8); hold(2'b01, 8); hold(2'b00, 8);
  endtask

  task automatic do_exit();
    hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8); hold(2'b00, 8);
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst_io", int'(io), 0);
    check("rst_reject", int'(reject), 0);
    check("rst_fault", int'(fault), 0);
    reset = 1'b0;
    step(1);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    hold(2'b00, 8);

    // Entry with exact pulse timing
    snap();
    hold(2'b10, 8); hold(2'b11, 8); hold(2'b01, 8);
    {a, b} = 2'b00;
    step(4);
    check("entry_io_early", int'(io), 0);
    step(1);
    check("entry_io_pulse", int'(io), 2);
    check("entry_cnt_before", int'(count), 0);
    step(1);
    check("entry_io_end", int'(io), 0);
    check("entry_cnt", int'(count), 1);
    step(6);
    check("entry_n_enter", n_enter - b_enter, 1);
    check("entry_n_fault", n_fault - b_fault, 0);

    // Exit from 3, then exit while empty
    load(6'd3);
    step(2);
    snap();
    do_exit();
    check("exit_n_exit", n_exit - b_exit, 1);
    check("exit_cnt", int'(count), 2);
    load(6'd0);
    step(2);
    snap();
    do_exit();
    check("exit_empty_n_exit", n_exit - b_exit, 0);
    check("exit_empty_cnt", int'(count), 0);
    check("exit_empty_fault", n_fault - b_fault, 0);

    // Glitch on a must leave the FSM idle: a following exit is still legal
    load(6'd3);
    snap();
    hold(2'b10, 1);
    hold(2'b00, 10);
    do_exit();
    check("glitch_n_exit", n_exit - b_exit, 1);
    check("glitch_fault", n_fault - b_fault, 0);
    check("glitch_cnt", int'(count), 2);

    // Back-out from E2 through E1
    snap();
    hold(2'b10, 8); hold(2'b11, 8); hold(2'b10, 8); hold(2'b00, 8);
    check("backout_io", (n_enter - b_enter) + (n_exit - b_exit), 0);
    check("backout_fault", n_fault - b_fault, 0);

    // Fill to capacity, then one more entry is rejected
    load(6'd0);
    step(2);
    for (int i = 0; i < 24; i++) do_entry();
    check("fill24_cnt", int'(count), 24);
    check("fill24_full", int'(full), 0);
    do_entry();
    check("fill25_cnt", int'(count), 25);
    check("fill25_full", int'(full), 1);
    snap();
    do_entry();
    check("over_cnt", int'(count), 25);
    check("over_n_enter", n_enter - b_enter, 0);
    check("over_n_rej", n_rej - b_rej, 1);

    // full/empty latency and count above capacity
    load(6'd0);
    step(2);
    load(6'd30);
    check("lat_full_old", int'(full), 0);
    check("lat_empty_old", int'(empty), 1);
    step(1);
    check("lat_full_new", int'(full), 1);
    check("lat_empty_new", int'(empty), 0);
    load(6'd0);
    step(2);

    // Illegal 00->11, fault once, ERR until 00
    snap();
    hold(2'b11, 28);
    check("illegal_fault", n_fault - b_fault, 1);
    hold(2'b00, 8);
    do_entry();
    check("illegal_recover_enter", n_enter - b_enter, 1);
    check("illegal_recover_fault", n_fault - b_fault, 1);

    // Timeout while held in E1
    snap();
    {a, b} = 2'b10;
    step(20);
    check("tmo_fault_before", int'(fault), 0);
    step(1);
    check("tmo_fault_pulse", int'(fault), 1);
    step(1);
    check("tmo_fault_after", int'(fault), 0);
    step(10);
    hold(2'b00, 8);
    check("tmo_n_fault", n_fault - b_fault, 1);
    check("tmo_io", (n_enter - b_enter) + (n_exit - b_exit), 0);

    // Reset while in E2
    load(6'd0);
    snap();
    hold(2'b10, 8); hold(2'b11, 8);
    reset = 1'b1;
    {a, b} = 2'b00;
    step(3);
    check("rstmid_io", int'(io), 0);
    reset = 1'b0;
    hold(2'b00, 8);
    check("rstmid_n_enter", n_enter - b_enter, 0);
    do_entry();
    check("rstmid_enter", n_enter - b_enter, 1);
    check("rstmid_cnt", int'(count), 1);
    check("rstmid_fault", n_fault - b_fault, 0);

    // Reset with both beams still blocked: IDLE sees 11 and faults
    snap();
    hold(2'b10, 8); hold(2'b11, 8);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(10);
    check("rstblk_fault", n_fault - b_fault, 1);
    hold(2'b00, 8);
    check("rstblk_io", (n_enter - b_enter) + (n_exit - b_exit), 0);

    check("never_both", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
